cd_scsi_initiator: RTL and testbench

- Host-side (initiator) end of the PCE CD-ROM SCSI-style link; the counterpart to the drive-side phase/status logic that drives BSY/REQ/MSG/CD/IO.
- Selects the target, then follows the target-chosen phase from the MSG/CD/IO bits:
  - sends command bytes;
  - returns data-in bytes to the CPU side over valid/ready;
  - latches the status and message bytes.
- Every byte moves through a full REQ/ACK interlock.
- Sits between the CPU register file (CDC command/data ports) and the drive model.

---
 rtl/cd_scsi_initiator.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_cd_scsi_initiator.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_scsi_initiator.sv
// SCSI-style initiator: select, follow target phase, move each byte under a REQ/ACK interlock.
// Data-in waits on i_RdReady before ACK; define CD_SEL_TIMEOUT_EN to abandon selection after SEL_TIMEOUT cycles.
module cd_scsi_initiator #(
    parameter int CMD_DEPTH   = 16,
    parameter int ACK_HOLD    = 2,
    parameter int SEL_TIMEOUT = 1024
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [7:0] i_CDStatus,
    input  logic [7:0] i_TgtData,
    output logic [7:0] o_InitData,
    output logic       o_SEL,
    output logic       o_ACK,
    input  logic       i_CmdWrEn,
    input  logic [7:0] i_CmdWrData,
    input  logic       i_Start,
    output logic [7:0] o_RdData,
    output logic       o_RdValid,
    input  logic       i_RdReady,
    output logic [7:0] o_StatusByte,
    output logic [7:0] o_MsgByte,
    output logic [7:0] o_Phase,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Error
);
    localparam int PW = $clog2(CMD_DEPTH + 1);
    localparam int IW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int AW = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(CMD_DEPTH);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_REQ, S_XFER, S_ACK_HI, S_WAIT_REQ_LO, S_DONE
    } state_t;

    logic       bsy, req;
    logic [2:0] ph_bits;
    logic       unused_status;
    assign bsy           = i_CDStatus[7];
    assign req           = i_CDStatus[6];
    assign ph_bits       = i_CDStatus[5:3];
    assign unused_status = ^i_CDStatus[2:0];

    state_t          state_q, state_d;
    logic [7:0]      cmd_mem_q [CMD_DEPTH];
    logic [7:0]      cmd_mem_d [CMD_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, len_q, len_d, idx_q, idx_d;
    logic [2:0]      xph_q, xph_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
    logic            msg_seen_q, msg_seen_d;
    logic            sel_q, sel_d, ack_q, ack_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      init_data_q, init_data_d, rd_data_q, rd_data_d;
    logic [7:0]      status_q, status_d, msg_q, msg_d, phase_q, phase_d;
    logic            go_ack;
`ifdef CD_SEL_TIMEOUT_EN
    localparam int TW = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(SEL_TIMEOUT - 1);
    logic [TW-1:0] sel_cnt_q, sel_cnt_d;
`else
    localparam int unused_sel_timeout = SEL_TIMEOUT;
`endif

    function automatic logic [7:0] decode_phase(input logic [2:0] p);
        case (p)
            3'b000:  return 8'h04;
            3'b001:  return 8'h02;
            3'b010:  return 8'h01;
            3'b011:  return 8'h08;
            3'b111:  return 8'h10;
            3'b110:  return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_mem_d   = cmd_mem_q;
        wptr_d      = wptr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        xph_d       = xph_q;
        ack_cnt_d   = ack_cnt_q;
        msg_seen_d  = msg_seen_q;
        sel_d       = sel_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        rd_valid_d  = rd_valid_q;
        init_data_d = init_data_q;
        rd_data_d   = rd_data_q;
        status_d    = status_q;
        msg_d       = msg_q;
        phase_d     = bsy ? decode_phase(ph_bits) : 8'h00;
        go_ack      = 1'b0;
`ifdef CD_SEL_TIMEOUT_EN
        sel_cnt_d   = sel_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_CmdWrEn) begin
                    if (wptr_q < DEPTH_P) begin
                        cmd_mem_d[wptr_q[IW-1:0]] = i_CmdWrData;
                        wptr_d = wptr_q + PW'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (i_Start) begin
                    error_d = (wptr_q == '0);
                    if (wptr_q != '0) begin
                        len_d      = wptr_q;
                        idx_d      = '0;
                        msg_seen_d = 1'b0;
                        sel_d      = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = S_SELECT;
`ifdef CD_SEL_TIMEOUT_EN
                        sel_cnt_d  = '0;
`endif
                    end
                end
            end
            S_SELECT: begin
                if (bsy) begin
                    sel_d   = 1'b0;
                    state_d = S_WAIT_REQ;
                end
`ifdef CD_SEL_TIMEOUT_EN
                else if (sel_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sel_cnt_d = sel_cnt_q + TW'(1);
                end
`endif
            end
            S_WAIT_REQ: begin
                if (!bsy) begin
                    // Bus-free is only a clean finish once the message-in byte has arrived.
                    error_d = error_q | ~msg_seen_q;
                    state_d = S_DONE;
                end else if (req) begin
                    xph_d   = ph_bits;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!bsy) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    case (xph_q)
                        3'b010: begin
                            go_ack = 1'b1;
                            if (idx_q < len_q) begin
                                init_data_d = cmd_mem_q[idx_q[IW-1:0]];
                            end else begin
                                init_data_d = 8'h00;
                                error_d     = 1'b1;
                            end
                        end
                        3'b001: begin
                            if (!rd_valid_q) begin
                                rd_data_d  = i_TgtData;
                                rd_valid_d = 1'b1;
                            end else if (i_RdReady) begin
                                rd_valid_d = 1'b0;
                                go_ack     = 1'b1;
                            end
                        end
                        3'b011: begin
                            status_d = i_TgtData;
                            go_ack   = 1'b1;
                        end
                        3'b111: begin
                            msg_d      = i_TgtData;
                            msg_seen_d = 1'b1;
                            go_ack     = 1'b1;
                        end
                        default: begin
                            init_data_d = 8'h00;
                            error_d     = 1'b1;
                            go_ack      = 1'b1;
                        end
                    endcase
                    if (go_ack) begin
                        ack_d     = 1'b1;
                        ack_cnt_d = '0;
                        state_d   = S_ACK_HI;
                    end
                end
            end
            S_ACK_HI: begin
                if (!bsy) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (ack_cnt_q < ACK_LAST) begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end else if (!req) begin
                    ack_d   = 1'b0;
                    state_d = S_WAIT_REQ_LO;
                end
            end
            S_WAIT_REQ_LO: begin
                if (xph_q == 3'b010 && idx_q < len_q) idx_d = idx_q + PW'(1);
                state_d = S_WAIT_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        // Every path into DONE releases the bus and raises the completion pulse.
        if (state_d == S_DONE) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            sel_d      = 1'b0;
            ack_d      = 1'b0;
            rd_valid_d = 1'b0;
            wptr_d     = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            cmd_mem_q   <= '{default: '0};
            wptr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            xph_q       <= '0;
            ack_cnt_q   <= '0;
            msg_seen_q  <= 1'b0;
            sel_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            init_data_q <= '0;
            rd_data_q   <= '0;
            status_q    <= '0;
            msg_q       <= '0;
            phase_q     <= '0;
`ifdef CD_SEL_TIMEOUT_EN
            sel_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_mem_q   <= cmd_mem_d;
            wptr_q      <= wptr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            xph_q       <= xph_d;
            ack_cnt_q   <= ack_cnt_d;
            msg_seen_q  <= msg_seen_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rd_valid_q  <= rd_valid_d;
            init_data_q <= init_data_d;
            rd_data_q   <= rd_data_d;
            status_q    <= status_d;
            msg_q       <= msg_d;
            phase_q     <= phase_d;
`ifdef CD_SEL_TIMEOUT_EN
            sel_cnt_q   <= sel_cnt_d;
`endif
        end
    end

    assign o_InitData   = init_data_q;
    assign o_SEL        = sel_q;
    assign o_ACK        = ack_q;
    assign o_RdData     = rd_data_q;
    assign o_RdValid    = rd_valid_q;
    assign o_StatusByte = status_q;
    assign o_MsgByte    = msg_q;
    assign o_Phase      = phase_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Error      = error_q;
endmodule

// File: tb/tb_cd_scsi_initiator.sv
// Bench for cd_scsi_initiator: the initial block plays the target and CPU; scoreboard queues hold expected bytes.
module tb_cd_scsi_initiator;
    localparam int ACK_HOLD    = 2;
    localparam int SEL_TIMEOUT = 1024;
    localparam logic [2:0] PH_DOUT = 3'b000, PH_DIN = 3'b001, PH_CMD = 3'b010;
    localparam logic [2:0] PH_STAT = 3'b011, PH_MSGI = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_CDStatus, i_TgtData, i_CmdWrData;
    logic       i_CmdWrEn, i_Start, i_RdReady;
    logic [7:0] o_InitData, o_RdData, o_StatusByte, o_MsgByte, o_Phase;
    logic       o_SEL, o_ACK, o_RdValid, o_Busy, o_Done, o_Error;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_cmd [$];
    logic [7:0] exp_rd  [$];

    always #5 clk = ~clk;

    cd_scsi_initiator #(.CMD_DEPTH(16), .ACK_HOLD(ACK_HOLD), .SEL_TIMEOUT(SEL_TIMEOUT)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_CDStatus(i_CDStatus), .i_TgtData(i_TgtData),
        .o_InitData(o_InitData), .o_SEL(o_SEL), .o_ACK(o_ACK), .i_CmdWrEn(i_CmdWrEn),
        .i_CmdWrData(i_CmdWrData), .i_Start(i_Start), .o_RdData(o_RdData), .o_RdValid(o_RdValid),
        .i_RdReady(i_RdReady), .o_StatusByte(o_StatusByte), .o_MsgByte(o_MsgByte), .o_Phase(o_Phase),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error)
    );

    function automatic logic [7:0] phase_onehot(input logic [2:0] p);
        case (p)
            PH_CMD:  return 8'h01;
            PH_DIN:  return 8'h02;
            PH_DOUT: return 8'h04;
            PH_STAT: return 8'h08;
            PH_MSGI: return 8'h10;
            default: return 8'h20;
        endcase
    endfunction

    task automatic set_bus(input logic bsy, input logic req, input logic [2:0] ph);
        i_CDStatus = {bsy, req, ph, 3'b000};
    endtask

    task automatic wait_ack(input logic lvl, output int hi_cycles, output bit ok);
        hi_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_ACK === lvl) begin
                ok = 1'b1;
                break;
            end
            if (o_ACK === 1'b1) hi_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic write_cmd(input logic [7:0] b);
        i_CmdWrEn = 1'b1;
        i_CmdWrData = b;
        exp_cmd.push_back(b);
        @(negedge clk);
        i_CmdWrEn = 1'b0;
    endtask

    task automatic start_and_select();
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        n_cmp++;
        if (o_SEL !== 1'b1 || o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL select_start: sel=%b busy=%b, want 1 1", o_SEL, o_Busy);
        end
        set_bus(1'b1, 1'b0, PH_DOUT);
        for (int i = 0; i < 10 && o_SEL !== 1'b0; i++) @(negedge clk);
        n_cmp++;
        if (o_SEL !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_release: sel=%b, want 0", o_SEL);
        end
    endtask

    // Target offers one byte in phase ph; data-in bytes are consumed after 'stall' not-ready cycles.
    task automatic tgt_byte(input logic [2:0] ph, input logic [7:0] d, input int stall);
        int hc;
        bit ok;
        bit held;
        logic [7:0] e;
        i_TgtData = d;
        set_bus(1'b1, 1'b1, ph);
        if (ph == PH_DIN) begin
            exp_rd.push_back(d);
            for (int i = 0; i < 100 && o_RdValid !== 1'b1; i++) @(negedge clk);
            e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
            held = 1'b1;
            for (int i = 0; i < stall; i++) begin
                if (o_RdValid !== 1'b1 || o_ACK !== 1'b0 || o_RdData !== e) held = 1'b0;
                @(negedge clk);
            end
            if (stall > 0) begin
                n_cmp++;
                if (!held) begin
                    n_fail++;
                    $display("FAIL rd_hold: valid=%b ack=%b data=%h, want 1 0 %h", o_RdValid, o_ACK, o_RdData, e);
                end
            end
            n_cmp++;
            if (o_RdValid !== 1'b1 || o_RdData !== e) begin
                n_fail++;
                $display("FAIL rd_data: valid=%b data=%h, want 1 %h", o_RdValid, o_RdData, e);
            end
            i_RdReady = 1'b1;
            @(negedge clk);
            i_RdReady = 1'b0;
            n_cmp++;
            if (o_RdValid !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_clear: valid=%b, want 0", o_RdValid);
            end
        end
        wait_ack(1'b1, hc, ok);
        n_cmp++;
        if (!ok || o_Phase !== phase_onehot(ph)) begin
            n_fail++;
            $display("FAIL ack_rise: ack=%b phase=%h, want 1 %h", o_ACK, o_Phase, phase_onehot(ph));
        end
        if (ph == PH_CMD) begin
            e = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 8'hxx;
            n_cmp++;
            if (o_InitData !== e) begin
                n_fail++;
                $display("FAIL cmd_byte: got %h, want %h", o_InitData, e);
            end
        end
        set_bus(1'b1, 1'b0, ph);
        wait_ack(1'b0, hc, ok);
        n_cmp++;
        if (!ok || hc < ACK_HOLD) begin
            n_fail++;
            $display("FAIL ack_hold: released=%b high_cycles=%0d, want 1 >=%0d", ok, hc, ACK_HOLD);
        end
    endtask

    task automatic bus_free_expect(input logic exp_err, input bit chk_sm, input logic [7:0] st, input logic [7:0] mg);
        int dc = 0;
        set_bus(1'b0, 1'b0, PH_DOUT);
        for (int i = 0; i < 20; i++) begin
            if (o_Done === 1'b1) dc++;
            @(negedge clk);
        end
        n_cmp++;
        if (dc != 1) begin
            n_fail++;
            $display("FAIL done_pulse: %0d cycles, want 1", dc);
        end
        n_cmp++;
        if (o_Error !== exp_err || o_Busy !== 1'b0 || o_Phase !== 8'h00 || o_ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL end_state: err=%b busy=%b phase=%h ack=%b, want %b 0 00 0", o_Error, o_Busy, o_Phase, o_ACK, exp_err);
        end
        if (chk_sm) begin
            n_cmp++;
            if (o_StatusByte !== st || o_MsgByte !== mg) begin
                n_fail++;
                $display("FAIL status_msg: got %h %h, want %h %h", o_StatusByte, o_MsgByte, st, mg);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_CDStatus = '0; i_TgtData = '0; i_CmdWrData = '0;
        i_CmdWrEn = 1'b0; i_Start = 1'b0; i_RdReady = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_SEL, o_ACK, o_Busy, o_Done, o_Error, o_RdValid} !== 6'b0 ||
            o_Phase !== 8'h00 || o_InitData !== 8'h00 || o_StatusByte !== 8'h00 || o_MsgByte !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b ack=%b busy=%b done=%b err=%b vld=%b phase=%h, want all 0",
                     o_SEL, o_ACK, o_Busy, o_Done, o_Error, o_RdValid, o_Phase);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] b [6];
        b = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) write_cmd(b[i]);
        start_and_select();
        for (int i = 0; i < 6; i++) tgt_byte(PH_CMD, 8'h00, 0);
        tgt_byte(PH_DIN, 8'hA5, 0);
        tgt_byte(PH_DIN, 8'h5A, 0);
        tgt_byte(PH_STAT, 8'h00, 0);
        tgt_byte(PH_MSGI, 8'h00, 0);
        bus_free_expect(1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++;
        if (exp_cmd.size() != 0) begin
            n_fail++;
            $display("FAIL cmd_count: %0d bytes never sent, want 0", exp_cmd.size());
        end
    endtask

    task automatic test_zero_len();
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_Error !== 1'b1 || o_Busy !== 1'b0 || o_SEL !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: err=%b busy=%b sel=%b, want 1 0 0", o_Error, o_Busy, o_SEL);
        end
    endtask

    task automatic test_rd_stall();
        write_cmd(8'h28);
        start_and_select();
        tgt_byte(PH_CMD, 8'h00, 0);
        tgt_byte(PH_DIN, 8'h3C, 10);
        tgt_byte(PH_DIN, 8'hC3, 0);
        tgt_byte(PH_STAT, 8'h02, 0);
        tgt_byte(PH_MSGI, 8'h04, 0);
        bus_free_expect(1'b0, 1'b1, 8'h02, 8'h04);
    endtask

    task automatic test_extra_cmd();
        logic [7:0] b [6];
        b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < 6; i++) write_cmd(b[i]);
        exp_cmd.push_back(8'h00);
        start_and_select();
        for (int i = 0; i < 7; i++) tgt_byte(PH_CMD, 8'h00, 0);
        n_cmp++;
        if (o_Error !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_err: err=%b, want 1", o_Error);
        end
        tgt_byte(PH_STAT, 8'h08, 0);
        tgt_byte(PH_MSGI, 8'h00, 0);
        bus_free_expect(1'b1, 1'b1, 8'h08, 8'h00);
    endtask

    task automatic test_bsy_drop();
        int hc;
        bit ok;
        write_cmd(8'h03);
        start_and_select();
        tgt_byte(PH_CMD, 8'h00, 0);
        i_TgtData = 8'h77;
        set_bus(1'b1, 1'b1, PH_DIN);
        for (int i = 0; i < 100 && o_RdValid !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (o_RdValid !== 1'b1 || o_RdData !== 8'h77) begin
            n_fail++;
            $display("FAIL drop_rd: valid=%b data=%h, want 1 77", o_RdValid, o_RdData);
        end
        i_RdReady = 1'b1;
        @(negedge clk);
        i_RdReady = 1'b0;
        wait_ack(1'b1, hc, ok);
        set_bus(1'b0, 1'b0, PH_DOUT);
        @(negedge clk);
        n_cmp++;
        if (!ok || o_ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ack: seen_high=%b ack=%b, want 1 0", ok, o_ACK);
        end
        bus_free_expect(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        int hc;
        bit ok;
        logic [7:0] e;
        write_cmd(8'hE1);
        start_and_select();
        i_TgtData = 8'h00;
        set_bus(1'b1, 1'b1, PH_CMD);
        wait_ack(1'b1, hc, ok);
        e = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 8'hxx;
        n_cmp++;
        if (!ok || o_InitData !== e) begin
            n_fail++;
            $display("FAIL rst_cmd: ack_seen=%b byte=%h, want 1 %h", ok, o_InitData, e);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_ACK !== 1'b0 || o_SEL !== 1'b0 || o_Busy !== 1'b0 || o_Phase !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: ack=%b sel=%b busy=%b phase=%h, want 0 0 0 00", o_ACK, o_SEL, o_Busy, o_Phase);
        end
        set_bus(1'b0, 1'b0, PH_DOUT);
        exp_cmd.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
    endtask

`ifdef CD_SEL_TIMEOUT_EN
    task automatic test_sel_timeout();
        int sc = 0;
        write_cmd(8'h00);
        exp_cmd.delete();
        set_bus(1'b0, 1'b0, PH_DOUT);
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        for (int i = 0; i < 2000 && o_SEL === 1'b1; i++) begin
            sc++;
            @(negedge clk);
        end
        n_cmp++;
        if (sc != SEL_TIMEOUT || o_Error !== 1'b1 || o_Done !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_timeout: sel_cycles=%0d err=%b done=%b, want %0d 1 1", sc, o_Error, o_Done, SEL_TIMEOUT);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_rd_stall();
        test_extra_cmd();
        test_bsy_drop();
        test_reset_mid();
`ifdef CD_SEL_TIMEOUT_EN
        test_sel_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
